// File: rtl/wb_trace_pkg.sv
// Shared constants and types for the writeback trace display: digit count,
// entry layout and the active-low gfedcba seven-segment glyph table.
package wb_trace_pkg;

   localparam int DIGITS  = 8;
   localparam int ENTRY_W = 64;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low gfedcba glyphs for hex digits 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

endpackage

// File: rtl/wb_trace_display_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_7seg
   import wb_trace_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/wb_trace_display.sv
// Captures each new (PC, write data) writeback pair into a FIFO and shows the head
// on an 8-digit multiplexed display. Optional live-view input Live: WB_TRACE_LIVE_EN.
module wb_trace_display
   import wb_trace_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [31:0]              PCDisplay,
   input  logic [31:0]              WriteDataDisplay,
   input  logic                     Advance,
   input  logic                     ShowData,
`ifdef WB_TRACE_LIVE_EN
   input  logic                     Live,
`endif
   output logic [6:0]               Seg,
   output logic [7:0]               An,
   output logic                     Dp,
   output logic                     Empty,
   output logic                     Overflow,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DIG_W  = $clog2(DIGITS);

   entry_t                cur_q, prev_q;
   logic                  push_q;

   logic [ENTRY_W-1:0]    mem_q [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic [REF_W-1:0]      refresh_q, refresh_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic                  show_q, show_d;
   logic [6:0]            seg_q, seg_d;
   logic [7:0]            an_q, an_d;
   logic                  dp_q, dp_d;

   logic                  fifo_empty, fifo_full, pop, do_push;
   entry_t                head, src;
   logic                  show_dash;
   logic [31:0]           word;
   logic [3:0]            nibble;
   logic [6:0]            hex_seg;

   // The inputs come straight from upstream combinational logic, so they are
   // registered once and a change is detected between successive samples.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, giving a true pipeline.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cur_q  <= '0;
         prev_q <= '0;
         push_q <= 1'b0;
      end else begin
         cur_q  <= {PCDisplay, WriteDataDisplay};
         prev_q <= cur_q;
         push_q <= (cur_q != prev_q);
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign pop        = Advance && !fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push    = push_q && (!fifo_full || pop);

   // NOTE: every combinational output gets a default first so no path
   // through the block leaves a variable unassigned (no latch inferred).
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !do_push) count_d = count_q - 1'b1;
      if (push_q && !do_push)   overflow_d = 1'b1;
   end

   // NOTE: the storage array has no reset; validity is tracked by the
   // pointers and count, which keeps it mappable onto plain RAM.
   always_ff @(posedge Clk) begin
      if (do_push) mem_q[wr_ptr_q] <= prev_q;
   end

   assign head = mem_q[rd_ptr_q];

`ifdef WB_TRACE_LIVE_EN
   assign src       = Live ? cur_q : head;
   assign show_dash = Live ? 1'b0 : fifo_empty;
`else
   assign src       = head;
   assign show_dash = fifo_empty;
`endif

   assign word   = show_q ? src.data : src.pc;
   assign nibble = word[{digit_q, 2'b00} +: 4];

   hex_to_7seg u_hex (
      .nibble_i (nibble),
      .seg_o    (hex_seg)
   );

   // The data/PC select is latched on each digit change so a digit never
   // flips source partway through its lit period.
   always_comb begin
      refresh_d = refresh_q + 1'b1;
      digit_d   = digit_q;
      show_d    = show_q;
      if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         digit_d   = digit_q + 1'b1;
         show_d    = ShowData;
      end
   end

   always_comb begin
      seg_d = show_dash ? SEG_DASH : hex_seg;
      an_d  = ~(8'b1 << digit_q);
      dp_d  = !((digit_q == DIG_W'(DIGITS - 1)) && overflow_q);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         refresh_q  <= '0;
         digit_q    <= '0;
         show_q     <= 1'b0;
         seg_q      <= SEG_DASH;
         an_q       <= 8'hFE;
         dp_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         refresh_q  <= refresh_d;
         digit_q    <= digit_d;
         show_q     <= show_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         dp_q       <= dp_d;
      end
   end

   assign Seg      = seg_q;
   assign An       = an_q;
   assign Dp       = dp_q;
   assign Empty    = fifo_empty;
   assign Overflow = overflow_q;
   assign Count    = count_q;

endmodule

// File: tb/tb_wb_trace_display.sv
// Bench for wb_trace_display: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_wb_trace_display;

   localparam int DEPTH = 4;
   localparam int R     = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [6:0] DASH = 7'b0111111;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic [31:0]   PCDisplay = '0;
   logic [31:0]   WriteDataDisplay = '0;
   logic          Advance = 1'b0;
   logic          ShowData = 1'b0;
   logic [6:0]    Seg;
   logic [7:0]    An;
   logic          Dp, Empty, Overflow;
   logic [CW-1:0] Count;
`ifdef WB_TRACE_LIVE_EN
   logic          Live = 1'b0;
`endif

   wb_trace_display #(.DEPTH(DEPTH), .REFRESH_DIV(R)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .PCDisplay        (PCDisplay),
      .WriteDataDisplay (WriteDataDisplay),
      .Advance          (Advance),
      .ShowData         (ShowData),
`ifdef WB_TRACE_LIVE_EN
      .Live             (Live),
`endif
      .Seg              (Seg),
      .An               (An),
      .Dp               (Dp),
      .Empty            (Empty),
      .Overflow         (Overflow),
      .Count            (Count)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   // Reference model: the FIFO is a queue, captures are scheduled events that
   // land two edges after the edge that first samples a changed input pair.
   typedef struct { int at; logic [63:0] v; } pend_t;
   logic [63:0] mq [$];
   pend_t       pend [$];
   bit          m_ovf = 0, m_show = 0, m_valid = 0;
   int          m_n = 0;
   logic [63:0] m_last = '0;
   logic [6:0]  e_seg = DASH;
   logic [7:0]  e_an = 8'hFE;
   logic        e_dp = 1'b1;

   initial begin
      int          d, e;
      logic [31:0] w, sh;
      logic [63:0] s, pv;
      bit          do_pop, do_push;
      forever begin
         @(posedge Clk);
         if (!Reset) begin
            mq.delete();
            pend.delete();
            m_ovf = 0; m_show = 0; m_n = 0; m_last = '0;
            e_seg = DASH; e_an = 8'hFE; e_dp = 1'b1;
            m_valid = 1;
         end else if (m_valid) begin
            d     = (m_n / R) % 8;
            e_an  = ~(8'd1 << d);
            e_dp  = !(d == 7 && m_ovf);
            if (mq.size() == 0) e_seg = DASH;
            else begin
               w     = m_show ? mq[0][31:0] : mq[0][63:32];
               sh    = w >> (4 * d);
               e_seg = glyph(sh[3:0]);
            end
            e = m_n + 1;
            s = {PCDisplay, WriteDataDisplay};
            if (s != m_last) pend.push_back('{e + 2, s});
            m_last  = s;
            do_pop  = Advance && (mq.size() > 0);
            do_push = (pend.size() > 0) && (pend[0].at == e);
            pv      = '0;
            if (do_push) begin
               pv = pend[0].v;
               void'(pend.pop_front());
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               if (mq.size() < DEPTH) mq.push_back(pv);
               else m_ovf = 1;
            end
            if (e % R == 0) m_show = ShowData;
            m_n = e;
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (m_valid) begin
            check("seg", Seg, e_seg);
            check("an", An, e_an);
            check("dp", Dp, e_dp);
            check("count", Count, mq.size());
            check("empty", Empty, mq.size() == 0);
            check("overflow", Overflow, m_ovf);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic step(input int k);
      repeat (k) @(posedge Clk);
      #2;
   endtask

   task automatic set_pair(input logic [31:0] pc, input logic [31:0] dat);
      PCDisplay        = pc;
      WriteDataDisplay = dat;
   endtask

   task automatic do_reset();
      set_pair(32'h0, 32'h0);
      Advance  = 1'b0;
      ShowData = 1'b0;
      Reset    = 1'b0;
      step(1);
      Reset    = 1'b1;
   endtask

   task automatic pulse_adv();
      Advance = 1'b1;
      step(1);
      Advance = 1'b0;
      step(1);
   endtask

   task automatic wait_an(input string name, input logic [7:0] target);
      bit ok = 0;
      for (int i = 0; i < 8 * R + 4; i++) begin
         if (An == target) begin
            ok = 1;
            break;
         end
         step(1);
      end
      check(name, ok, 1'b1);
   endtask

   logic [31:0] pool [4];

   initial begin
      // Reset mid-operation
      step(2);
      Reset = 1'b1;
      set_pair(32'h1, 32'h11); step(2);
      set_pair(32'h2, 32'h22); step(2);
      set_pair(32'h3, 32'h33); step(4);
      check("pre_reset_count", Count, 3);
      set_pair(32'h0, 32'h0);
      Reset = 1'b0;
      step(1);
      check("rst_count", Count, 0);
      check("rst_empty", Empty, 1'b1);
      check("rst_overflow", Overflow, 1'b0);
      check("rst_an", An, 8'hFE);
      check("rst_seg", Seg, DASH);
      Reset = 1'b1;

      // Capture latency
      set_pair(32'h4, 32'h14); step(4);
      check("first_capture", Count, 1);
      pulse_adv();
      check("popped", Count, 0);
      set_pair(32'h8, 32'h14);
      step(1); check("lat_1", Count, 0);
      step(1); check("lat_2", Count, 0);
      step(1); check("lat_3", Count, 1);
      ShowData = 1'b1;
      step(8 * R + 2);
      wait_an("wait_d0", 8'hFE);
      check("data_d0", Seg, 7'b0011001);
      wait_an("wait_d1", 8'hFD);
      check("data_d1", Seg, 7'b1111001);

      // Stable input
      step(100);
      check("stable_count", Count, 1);

      // Full with overflow
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_pair(32'hA + i, 32'h100 * (i + 1));
         step(2);
      end
      step(4);
      check("full_count", Count, 4);
      check("full_overflow", Overflow, 1'b1);
      wait_an("wait_d7", 8'h7F);
      check("dp_d7", Dp, 1'b0);
      wait_an("wait_d0b", 8'hFE);
      check("dp_d0", Dp, 1'b1);
      check("head_first", Seg, 7'b0001000);

      // Full with simultaneous pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_pair(32'h21 + i, 32'h5);
         step(2);
      end
      step(4);
      check("full2_count", Count, 4);
      set_pair(32'h25, 32'h5);
      step(2);
      Advance = 1'b1;
      step(1);
      Advance = 1'b0;
      check("pushpop_count", Count, 4);
      check("pushpop_overflow", Overflow, 1'b0);
      step(1);
      for (int i = 0; i < 3; i++) pulse_adv();
      check("tail_count", Count, 1);
      wait_an("wait_d0c", 8'hFE);
      check("tail_head", Seg, 7'b0010010);

      // Pops to empty across pointer wrap
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_pair(32'h30 + i, 32'h0);
         step(4);
         pulse_adv();
      end
      set_pair(32'h41, 32'h0); step(2);
      set_pair(32'h42, 32'h0); step(4);
      check("two_count", Count, 2);
      pulse_adv();
      pulse_adv();
      check("empty_after_2", Empty, 1'b1);
      pulse_adv();
      check("ignored_pop", Count, 0);
      for (int i = 0; i < 8 * R; i++) begin
         check("dash_all", Seg, DASH);
         step(1);
      end
      set_pair(32'h47, 32'h0); step(4);
      check("recapture", Count, 1);
      wait_an("wait_d0d", 8'hFE);
      check("recapture_head", Seg, 7'b1111000);

      // Randomized phase
      for (int i = 0; i < 4; i++) pool[i] = $urandom;
      for (int i = 0; i < 3000; i++) begin
         Reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 3) == 0)
            set_pair(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]);
         Advance = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) ShowData = ~ShowData;
         step(1);
      end
      Reset   = 1'b1;
      Advance = 1'b0;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_trace_display.md
Name: wb_trace_display

Overview:
- Receive end of the processor's writeback debug trace: consumes PCDisplay/WriteDataDisplay from the pipeline top and captures each new (PC, data) pair into a FIFO.
- Shows the FIFO head on an 8-digit, active-low, multiplexed seven-segment display; a step pulse pops to the next entry.
- Sits beside the processor top on the board wrapper; it is the human-readable reader for the pipeline's display writer.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- REFRESH_DIV, 100000, clock cycles each digit stays lit per scan.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- PCDisplay  in  32  PC of last displayed writeback, from processor top
- WriteDataDisplay  in  32  write data of that writeback
- Advance  in  1  debounced single-cycle pulse; pop FIFO head
- ShowData  in  1  0 = show PC of head, 1 = show data of head
- Seg  out  7  segments gfedcba, active-low
- An  out  8  digit anodes, active-low; An[0] = rightmost, least-significant nibble
- Dp  out  1  decimal point, active-low
- Empty  out  1  FIFO empty
- Overflow  out  1  sticky: a capture was dropped
- Count  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (Clk edge with Reset=0): FIFO flushed, Count=0, Empty=1, Overflow=0, scan digit=0, refresh counter=0, An=8'hFE, Seg=7'b0111111 (dash), Dp=1, capture register cleared to 0.
- Capture stage: {PCDisplay, WriteDataDisplay} registered every cycle into cur. Inputs are combinationally driven upstream, so they are never used unregistered.
- Push condition: cur differs from the previous registered value, which is also held. First detection is 2 cycles after an input change; Count increments on the following edge.
- Push when full: entry dropped, Overflow set, and Overflow stays set until reset.
- Pop: Advance=1 and not Empty; the head moves forward. Advance while Empty is ignored.
- Simultaneous push and pop: both happen and Count is unchanged. This also applies when full: the pop frees the slot, so no overflow.
- Pointers: ADDR_W-bit, wrapping modulo DEPTH. Count is derived from a separate counter, not pointer difference.
- Display source: head entry, PC when ShowData=0, data when ShowData=1. Switching ShowData takes effect on the next scan digit.
- Empty display: all digits show dash, Dp=1.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. On terminal count the digit index increments mod 8. An drives one-cold on the digit index; Seg shows nibble [4*i+3:4*i] of the selected word.
- Dp: low on digit 7 when Overflow=1, otherwise high.
- Seg and An are registered, updating 1 cycle after a digit index or source change.

Optional Feature:
- Macro: WB_TRACE_LIVE_EN.
- Defined: adds input port Live (1 bit). While Live=1, the display source is cur (live registered inputs) instead of the FIFO head, with the same ShowData select. The empty-dash rule is ignored in live mode. FIFO capture continues, and Advance still pops.
- Undefined: no Live port; the display always shows the FIFO head.

Decomposition:
- Package wb_trace_pkg:
  - DIGITS=8.
  - ENTRY_W=64.
  - Segment constants SEG_DASH=7'b0111111 and SEG_BLANK=7'b1111111.
  - 16-entry hex-to-segment table, active-low gfedcba, e.g. 0=7'b1000000, 4=7'b0011001, A=7'b0001000, F=7'b0001110.
- Sub-module hex_to_7seg: combinational 4-bit to 7-bit lookup using the package table; one instance after the nibble mux.
- FIFO storage and control stay inline.

Test Plan:
- Reset mid-operation:
  - Stimulus: push 3 entries, then hold Reset=0 for 1 cycle.
  - Required: Count=0, Empty=1, Overflow=0, An=8'hFE, Seg=7'b0111111.
- Capture latency:
  - Stimulus: PCDisplay changes 4 -> 8 with WriteDataDisplay=32'h0000_0014, REFRESH_DIV=4.
  - Required: Count=1 exactly 3 cycles after the change.
  - Required: ShowData=1, digit 0 shows Seg=7'b0011001 ('4') and digit 1 shows Seg=7'b1111001 ('1').
- Stable input: inputs held constant 100 cycles after a capture -> Count stays 1, no duplicate push.
- Full with overflow:
  - Stimulus: DEPTH=4, 5 distinct pairs pushed.
  - Required: Count=4, Overflow=1, Dp low only while An=8'h7F, head holds the first pair.
- Full with pop:
  - Stimulus: FIFO full, new pair arrives in the same cycle as Advance.
  - Required: Count stays 4, Overflow stays 0 (fresh reset), new pair becomes the tail.
- Pops to empty:
  - Stimulus: 2 pushes, then 3 Advance pulses.
  - Required: Empty=1 after the 2nd pop, the 3rd pulse is ignored, all digits show dash.
  - Required: the next capture becomes head, with no pointer corruption across wrap.
